stream_mux_rr: RTL and testbench

//  Registered N-channel stream multiplexer with valid/ready handshake on every input and on the output.
//  Two selection modes:
//  - Fixed-select: channel chosen by sel.
//  - Round-robin: fair arbitration among valid channels.

---
 rtl/stream_mux_rr.sv | 121 ++++++++++++
 tb/tb_stream_mux_rr.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_rr.sv
// stream_mux_rr
// Registered N-channel stream multiplexer with a valid/ready handshake on
// every input channel and on the single output. The channel is picked either
// by an explicit select or by round-robin among the valid channels. One output
// beat is held in a register so back-pressure never corrupts data.

module stream_mux_rr #(
    parameter int width  = 4,
    parameter int chn    = 4,
    parameter int swidth = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [chn*width-1:0]   i,
    input  logic [chn-1:0]         i_valid,
    output logic [chn-1:0]         i_ready,
    input  logic                   mode,
    input  logic [swidth-1:0]      sel,
    output logic [width-1:0]       o,
    output logic [swidth-1:0]      o_ch,
    output logic                   o_valid,
    input  logic                   o_ready
);

    logic [width-1:0]  o_q, o_d;
    logic [swidth-1:0] o_ch_q, o_ch_d;
    logic              o_valid_q, o_valid_d;
    logic [swidth-1:0] ptr_q, ptr_d;

    logic              grant_valid;
    logic [swidth-1:0] grant_idx;
    logic [width-1:0]  grant_data;
    logic              slot_free;
    logic              take;
    int                scan_off;
    int                best_off;

    // Pick the channel to serve this cycle: the selected one in fixed mode, or
    // the valid channel closest at or after the round-robin pointer otherwise.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_off    = 0;
        best_off    = chn;
        if (!mode) begin
            for (int k = 0; k < chn; k++) begin
                if ((int'(sel) == k) && i_valid[k]) begin
                    grant_valid = 1'b1;
                    grant_idx   = swidth'(k);
                end
            end
        end else begin
            for (int k = 0; k < chn; k++) begin
                if (i_valid[k]) begin
                    scan_off = (k + chn - int'(ptr_q)) % chn;
                    if (scan_off < best_off) begin
                        best_off    = scan_off;
                        grant_valid = 1'b1;
                        grant_idx   = swidth'(k);
                    end
                end
            end
        end
    end

    // Route the granted channel's data and form the one-hot accept strobe.
    always_comb begin
        grant_data = '0;
        i_ready    = '0;
        slot_free  = !o_valid_q || o_ready;
        take       = !rst && slot_free && grant_valid;
        for (int k = 0; k < chn; k++) begin
            if (swidth'(k) == grant_idx) begin
                grant_data = i[k*width +: width];
                i_ready[k] = take;
            end
        end
    end

    // Next state of the output holding register and round-robin pointer.
    always_comb begin
        o_d       = o_q;
        o_ch_d    = o_ch_q;
        o_valid_d = o_valid_q;
        ptr_d     = ptr_q;
        if (take) begin
            o_d       = grant_data;
            o_ch_d    = grant_idx;
            o_valid_d = 1'b1;
            if (mode) begin
                if (int'(grant_idx) == chn - 1) begin
                    ptr_d = '0;
                end else begin
                    ptr_d = swidth'(int'(grant_idx) + 1);
                end
            end
        end else if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset; a held beat is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q       <= '0;
            o_ch_q    <= '0;
            o_valid_q <= 1'b0;
            ptr_q     <= '0;
        end else begin
            o_q       <= o_d;
            o_ch_q    <= o_ch_d;
            o_valid_q <= o_valid_d;
            ptr_q     <= ptr_d;
        end
    end

    assign o       = o_q;
    assign o_ch    = o_ch_q;
    assign o_valid = o_valid_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr
// Drives directed scenarios followed by randomized traffic into stream_mux_rr
// and compares every cycle against a transaction-level reference model.

module tb_stream_mux_rr;

    localparam int W   = 4;
    localparam int CHN = 4;
    localparam int SW  = 2;

    logic              clk;
    logic              rst;
    logic [CHN*W-1:0]  i;
    logic [CHN-1:0]    i_valid;
    logic [CHN-1:0]    i_ready;
    logic              mode;
    logic [SW-1:0]     sel;
    logic [W-1:0]      o;
    logic [SW-1:0]     o_ch;
    logic              o_valid;
    logic              o_ready;

    int checks;
    int errors;

    // Reference model: the single held beat plus the round-robin pointer.
    bit m_valid;
    int m_data;
    int m_ch;
    int m_ptr;

    logic [CHN-1:0] exp_ready;
    bit             exp_found;
    int             exp_ch;

    stream_mux_rr #(.width(W), .chn(CHN), .swidth(SW)) dut (
        .clk     (clk),
        .rst     (rst),
        .i       (i),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .mode    (mode),
        .sel     (sel),
        .o       (o),
        .o_ch    (o_ch),
        .o_valid (o_valid),
        .o_ready (o_ready)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expectation and log mismatches.
    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s got %0d expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    // Drive one cycle's worth of inputs.
    task automatic applyStimulus(input bit r, input logic [CHN*W-1:0] data,
                                 input logic [CHN-1:0] valid, input bit md,
                                 input int s, input bit ordy);
        rst     = r;
        i       = data;
        i_valid = valid;
        mode    = md;
        sel     = SW'(s);
        o_ready = ordy;
    endtask

    // Which channel the rules say is served, given current inputs and model state.
    task automatic modelGrant(output bit found, output int ch);
        found = 1'b0;
        ch    = 0;
        if (!mode) begin
            if (int'(sel) < CHN && i_valid[sel]) begin
                found = 1'b1;
                ch    = int'(sel);
            end
        end else begin
            for (int s = 0; s < CHN; s++) begin
                int c;
                c = (m_ptr + s) % CHN;
                if (!found && i_valid[c]) begin
                    found = 1'b1;
                    ch    = c;
                end
            end
        end
    endtask

    // One clock: check accept strobes before the edge, advance the model at
    // the edge, then check the registered outputs just after it.
    task automatic runCycle();
        bit slot;
        @(negedge clk);
        modelGrant(exp_found, exp_ch);
        slot      = !m_valid || o_ready;
        exp_ready = '0;
        if (!rst && slot && exp_found) exp_ready[exp_ch] = 1'b1;
        checkOutput("i_ready", int'(i_ready), int'(exp_ready));
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0;
            m_data  = 0;
            m_ch    = 0;
            m_ptr   = 0;
        end else if (exp_ready != '0) begin
            m_valid = 1'b1;
            m_data  = int'(i[exp_ch*W +: W]);
            m_ch    = exp_ch;
            if (mode) m_ptr = (exp_ch + 1) % CHN;
        end else if (m_valid && o_ready) begin
            m_valid = 1'b0;
        end
        #1;
        checkOutput("o_valid", int'(o_valid), int'(m_valid));
        checkOutput("o", int'(o), m_data);
        checkOutput("o_ch", int'(o_ch), m_ch);
    endtask

    localparam logic [CHN*W-1:0] DCBA = 16'hDCBA;

    logic [W-1:0] chdata [CHN];
    logic [CHN-1:0] accepted;
    logic [CHN*W-1:0] packed_data;

    // Test sequence.
    initial begin
        checks = 0;
        errors = 0;
        m_valid = 0; m_data = 0; m_ch = 0; m_ptr = 0;

        // Reset with every channel offering a beat.
        applyStimulus(1, DCBA, 4'hF, 1, 0, 1);
        runCycle();
        runCycle();
        applyStimulus(0, DCBA, 4'hF, 1, 0, 1);
        runCycle();
        checkOutput("first_grant_ch", int'(o_ch), 0);
        checkOutput("first_grant_o", int'(o), 4'hA);

        // Fixed-select on channel 2.
        applyStimulus(0, DCBA, 4'hF, 0, 2, 1);
        for (int n = 0; n < 4; n++) runCycle();
        checkOutput("fixed_o", int'(o), 4'hC);

        // Round-robin fairness from a fresh pointer.
        applyStimulus(1, DCBA, 4'hF, 1, 0, 1);
        runCycle();
        applyStimulus(0, DCBA, 4'hF, 1, 0, 1);
        for (int n = 0; n < 8; n++) begin
            runCycle();
            checkOutput("rr_seq_ch", int'(o_ch), n % CHN);
        end

        // Sparse round-robin: move pointer to 2, then only ch1/ch3 valid.
        applyStimulus(1, DCBA, 4'hF, 1, 0, 1);
        runCycle();
        applyStimulus(0, DCBA, 4'hF, 1, 0, 1);
        runCycle();
        runCycle();
        applyStimulus(0, DCBA, 4'b1010, 1, 0, 1);
        for (int n = 0; n < 4; n++) begin
            runCycle();
            checkOutput("sparse_ch", int'(o_ch), (n % 2 == 0) ? 3 : 1);
        end

        // Back-pressure: hold B on ch1, then release with no bubble.
        applyStimulus(1, DCBA, 4'hF, 0, 1, 0);
        runCycle();
        applyStimulus(0, DCBA, 4'hF, 0, 1, 0);
        for (int n = 0; n < 4; n++) runCycle();
        checkOutput("stall_o", int'(o), 4'hB);
        applyStimulus(0, DCBA, 4'hF, 0, 2, 1);
        runCycle();
        checkOutput("release_o", int'(o), 4'hC);
        checkOutput("release_valid", int'(o_valid), 1);

        // Reset during a stall discards the held beat.
        applyStimulus(0, DCBA, 4'hF, 1, 0, 0);
        runCycle();
        applyStimulus(1, DCBA, 4'hF, 1, 0, 0);
        runCycle();
        applyStimulus(0, DCBA, 4'h0, 1, 0, 1);
        runCycle();
        checkOutput("post_reset_valid", int'(o_valid), 0);

        // Randomized traffic; each producer holds its beat until accepted.
        for (int k = 0; k < CHN; k++) chdata[k] = W'($urandom);
        accepted = '0;
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < CHN; k++) begin
                if (accepted[k]) begin
                    chdata[k]  = W'($urandom);
                    i_valid[k] = ($urandom_range(0, 1) == 1);
                end else if (!i_valid[k]) begin
                    i_valid[k] = ($urandom_range(0, 2) != 0);
                end
                packed_data[k*W +: W] = chdata[k];
            end
            applyStimulus(($urandom_range(0, 49) == 0), packed_data, i_valid,
                          ($urandom_range(0, 3) != 0), $urandom_range(0, CHN - 1),
                          ($urandom_range(0, 3) != 0));
            runCycle();
            accepted = exp_ready & i_valid;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
